// File: rtl/traffic_light_pkg.sv
// -----------------------------------------------------------------------------
// traffic_light_pkg
// Shared definitions for the traffic light controller and its monitor.
//   - light group encodings (one-hot GREEN/YELLOW/RED)
//   - phase codes P1..P6 and PH_INVALID
//   - default per-phase dwell times in clock cycles
//   - bit positions inside the monitor's err_sticky vector
//   - monitor synchronisation state and the phase successor function
// -----------------------------------------------------------------------------
package traffic_light_pkg;

  // One-hot light encodings for a single 3-bit light group.
  localparam logic [2:0] GREEN  = 3'b001;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] RED    = 3'b100;

  // Phase codes as seen on the monitor's phase output.
  typedef enum logic [2:0] {
    PH_P1      = 3'd0,
    PH_P2      = 3'd1,
    PH_P3      = 3'd2,
    PH_P4      = 3'd3,
    PH_P5      = 3'd4,
    PH_P6      = 3'd5,
    PH_INVALID = 3'd7
  } phase_e;

  // Default dwell times (cycles). The controller uses the same values.
  localparam int DWELL_P1_DEF = 8;
  localparam int DWELL_P2_DEF = 3;
  localparam int DWELL_P3_DEF = 6;
  localparam int DWELL_P4_DEF = 3;
  localparam int DWELL_P5_DEF = 4;
  localparam int DWELL_P6_DEF = 3;

  // Bit positions inside err_sticky: {dwell, seq, conflict, pattern}.
  localparam int STK_PATTERN  = 0;
  localparam int STK_CONFLICT = 1;
  localparam int STK_SEQ      = 2;
  localparam int STK_DWELL    = 3;

  // Monitor synchronisation state; the locked output is this state.
  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } mon_state_e;

  // Legal successor of a phase, wrapping P6 -> P1.
  function automatic phase_e next_phase(input phase_e p);
    case (p)
      PH_P1:   return PH_P2;
      PH_P2:   return PH_P3;
      PH_P3:   return PH_P4;
      PH_P4:   return PH_P5;
      PH_P5:   return PH_P6;
      PH_P6:   return PH_P1;
      default: return PH_INVALID;
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_phase_decoder.sv
// -----------------------------------------------------------------------------
// traffic_light_phase_decoder
// Purely combinational decode of the four light groups into a phase code.
// Ports:
//   i_m1, i_m2, i_mt, i_s : 3-bit light groups (main 1, main 2, main turn, side)
//   o_phase               : P1..P6, or PH_INVALID for any other tuple
//   o_phase_valid         : tuple is exactly one of the six legal phases
//   o_conflict            : MT green with M2 green, or S green with any green
// A group that is not exactly one-hot cannot match a legal tuple, so it
// decodes to PH_INVALID without a separate one-hot check.
// -----------------------------------------------------------------------------
module traffic_light_phase_decoder
  import traffic_light_pkg::*;
(
  input  logic [2:0] i_m1,
  input  logic [2:0] i_m2,
  input  logic [2:0] i_mt,
  input  logic [2:0] i_s,
  output phase_e     o_phase,
  output logic       o_phase_valid,
  output logic       o_conflict
);

  logic [11:0] w_tuple;
  logic        w_g_m1;
  logic        w_g_m2;
  logic        w_g_mt;
  logic        w_g_s;

  assign w_tuple = {i_m1, i_m2, i_mt, i_s};

  assign w_g_m1 = (i_m1 == GREEN);
  assign w_g_m2 = (i_m2 == GREEN);
  assign w_g_mt = (i_mt == GREEN);
  assign w_g_s  = (i_s  == GREEN);

  always_comb begin
    o_phase = PH_INVALID;
    case (w_tuple)
      {GREEN,  GREEN,  RED,    RED   }: o_phase = PH_P1;
      {GREEN,  YELLOW, RED,    RED   }: o_phase = PH_P2;
      {GREEN,  RED,    GREEN,  RED   }: o_phase = PH_P3;
      {YELLOW, RED,    YELLOW, RED   }: o_phase = PH_P4;
      {RED,    RED,    RED,    GREEN }: o_phase = PH_P5;
      {RED,    RED,    RED,    YELLOW}: o_phase = PH_P6;
      default:                          o_phase = PH_INVALID;
    endcase
  end

  assign o_phase_valid = (o_phase != PH_INVALID);

  // Turn-lane green crosses main road 2; side-road green crosses everything.
  assign o_conflict = (w_g_mt & w_g_m2) | (w_g_s & (w_g_m1 | w_g_m2 | w_g_mt));

endmodule

// File: rtl/traffic_light_monitor.sv
// -----------------------------------------------------------------------------
// traffic_light_monitor
// Passive checker on the traffic light controller's light bus. It never drives
// the lights; it decodes every sample to a phase, locks onto the phase cycle
// and checks phase order, per-phase dwell time and right-of-way safety.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   light_M1/M2/MT/S    : 3-bit light groups (001 green, 010 yellow, 100 red)
//   clr_err             : clears err_sticky (a pulse on the same edge wins)
//   phase, phase_valid  : decoded phase (0..5 = P1..P6, 7 = invalid)
//   locked              : monitor is synchronised to the phase cycle
//   err_pattern         : pulse, sample is not a legal phase tuple
//   err_conflict        : pulse, conflicting greens present
//   err_seq             : pulse, illegal phase transition while locked
//   err_dwell           : pulse, phase left too early, or overstayed
//   err_sticky          : {dwell, seq, conflict, pattern}, set-only until clr_err
//   cycles_done         : locked P6->P1 wraps, modulo 2^CNT_W
//
// Pipeline: stage 1 registers the lights, stage 2 registers decode and check
// results, so a light value driven in cycle k shows on the outputs in k+2.
// err_sticky updates on the same edge as the pulses it collects.
//
// Handshake: none. The monitor samples the bus every cycle unconditionally;
// there is no valid/ready flow control on any port.
// -----------------------------------------------------------------------------
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int DWELL_P1 = DWELL_P1_DEF,
  parameter int DWELL_P2 = DWELL_P2_DEF,
  parameter int DWELL_P3 = DWELL_P3_DEF,
  parameter int DWELL_P4 = DWELL_P4_DEF,
  parameter int DWELL_P5 = DWELL_P5_DEF,
  parameter int DWELL_P6 = DWELL_P6_DEF,
  // Every DWELL_Px must be <= 2^DW_W-2 so the overstay compare is reachable
  // before the dwell counter saturates.
  parameter int DW_W     = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       light_M1,
  input  logic [2:0]       light_M2,
  input  logic [2:0]       light_MT,
  input  logic [2:0]       light_S,
  input  logic             clr_err,
  output logic [2:0]       phase,
  output logic             phase_valid,
  output logic             locked,
  output logic             err_pattern,
  output logic             err_conflict,
  output logic             err_seq,
  output logic             err_dwell,
  output logic [3:0]       err_sticky,
  output logic [CNT_W-1:0] cycles_done
);

  // ---------------------------------------------------------------------------
  // Stage 1: light sample registers
  // ---------------------------------------------------------------------------
  logic [2:0] r_m1;
  logic [2:0] r_m2;
  logic [2:0] r_mt;
  logic [2:0] r_s;
  // The zeroed sample register right after reset is not a bus sample; stage 2
  // ignores it so a reset alone never raises err_pattern.
  logic       r_s1_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_m1     <= '0;
      r_m2     <= '0;
      r_mt     <= '0;
      r_s      <= '0;
      r_s1_vld <= 1'b0;
    end else begin
      r_m1     <= light_M1;
      r_m2     <= light_M2;
      r_mt     <= light_MT;
      r_s      <= light_S;
      r_s1_vld <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Decode of the stage-1 sample
  // ---------------------------------------------------------------------------
  phase_e w_dec_phase;
  logic   w_dec_valid;
  logic   w_dec_conflict;

  traffic_light_phase_decoder u_dec (
    .i_m1          (r_m1),
    .i_m2          (r_m2),
    .i_mt          (r_mt),
    .i_s           (r_s),
    .o_phase       (w_dec_phase),
    .o_phase_valid (w_dec_valid),
    .o_conflict    (w_dec_conflict)
  );

  // ---------------------------------------------------------------------------
  // Stage 2 state
  // ---------------------------------------------------------------------------
  mon_state_e       r_state;
  // r_phase is both the phase output and the "previous phase" the next sample
  // is compared against; PH_INVALID after reset or an invalid sample.
  phase_e           r_phase;
  logic             r_phase_valid;
  logic [DW_W-1:0]  r_dwell_cnt;
  logic             r_over;
  logic [CNT_W-1:0] r_cycles;
  logic [3:0]       r_pulse;
  logic [3:0]       r_sticky;

  mon_state_e       w_state_nxt;
  phase_e           w_phase_nxt;
  logic             w_valid_nxt;
  logic [DW_W-1:0]  w_cnt_nxt;
  logic             w_over_nxt;
  logic [CNT_W-1:0] w_cycles_nxt;
  logic [3:0]       w_pulse;
  logic [3:0]       w_sticky_nxt;
  logic [DW_W-1:0]  w_dwell_exp;

  // Required dwell of a phase; only meaningful for P1..P6.
  function automatic logic [DW_W-1:0] dwell_of(input phase_e p);
    case (p)
      PH_P1:   return DW_W'(DWELL_P1);
      PH_P2:   return DW_W'(DWELL_P2);
      PH_P3:   return DW_W'(DWELL_P3);
      PH_P4:   return DW_W'(DWELL_P4);
      PH_P5:   return DW_W'(DWELL_P5);
      PH_P6:   return DW_W'(DWELL_P6);
      default: return '0;
    endcase
  endfunction

  assign w_dwell_exp = dwell_of(r_phase);

  always_comb begin
    w_state_nxt  = r_state;
    w_phase_nxt  = r_phase;
    w_valid_nxt  = r_phase_valid;
    w_cnt_nxt    = r_dwell_cnt;
    w_over_nxt   = r_over;
    w_cycles_nxt = r_cycles;
    w_pulse      = '0;

    if (r_s1_vld) begin
      w_phase_nxt           = w_dec_phase;
      w_valid_nxt           = w_dec_valid;
      w_pulse[STK_PATTERN]  = ~w_dec_valid;
      w_pulse[STK_CONFLICT] = w_dec_conflict;

      if (!w_dec_valid) begin
        // Invalid sample: drop synchronisation, next valid phase starts fresh.
        w_state_nxt = ST_UNLOCKED;
        w_cnt_nxt   = '0;
        w_over_nxt  = 1'b0;
      end else if (w_dec_phase != r_phase) begin
        // Phase change: new phase has been seen once.
        w_cnt_nxt  = DW_W'(1);
        w_over_nxt = 1'b0;
        case (r_state)
          ST_UNLOCKED: begin
            // First change between two valid phases locks without checks;
            // a change out of PH_INVALID does not count.
            if (r_phase != PH_INVALID) w_state_nxt = ST_LOCKED;
          end
          ST_LOCKED: begin
            // A wrong successor still gets the departing phase's dwell check;
            // the monitor then simply follows the new phase.
            w_pulse[STK_SEQ]   = (w_dec_phase != next_phase(r_phase));
            w_pulse[STK_DWELL] = (r_dwell_cnt != w_dwell_exp) && !r_over;
            if (r_phase == PH_P6 && w_dec_phase == PH_P1)
              w_cycles_nxt = r_cycles + CNT_W'(1);
          end
          default: w_state_nxt = ST_UNLOCKED;
        endcase
      end else begin
        // Phase held: count, saturating at all-ones.
        if (r_dwell_cnt != '1) w_cnt_nxt = r_dwell_cnt + DW_W'(1);
        // Counter already at the full dwell and the phase is still there:
        // overstay, reported once; r_over also mutes the change check later.
        if (r_state == ST_LOCKED && !r_over && r_dwell_cnt == w_dwell_exp) begin
          w_pulse[STK_DWELL] = 1'b1;
          w_over_nxt         = 1'b1;
        end
      end
    end

    // Pulses are OR-ed in after the clear so a coincident pulse survives.
    w_sticky_nxt = (clr_err ? 4'b0000 : r_sticky) | w_pulse;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_UNLOCKED;
      r_phase       <= PH_INVALID;
      r_phase_valid <= 1'b0;
      r_dwell_cnt   <= '0;
      r_over        <= 1'b0;
      r_cycles      <= '0;
      r_pulse       <= '0;
      r_sticky      <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_phase       <= w_phase_nxt;
      r_phase_valid <= w_valid_nxt;
      r_dwell_cnt   <= w_cnt_nxt;
      r_over        <= w_over_nxt;
      r_cycles      <= w_cycles_nxt;
      r_pulse       <= w_pulse;
      r_sticky      <= w_sticky_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign phase        = r_phase;
  assign phase_valid  = r_phase_valid;
  assign locked       = (r_state == ST_LOCKED);
  assign err_pattern  = r_pulse[STK_PATTERN];
  assign err_conflict = r_pulse[STK_CONFLICT];
  assign err_seq      = r_pulse[STK_SEQ];
  assign err_dwell    = r_pulse[STK_DWELL];
  assign err_sticky   = r_sticky;
  assign cycles_done  = r_cycles;

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Passive checker on the light bus of the traffic light controller.
- Samples the four 3-bit light groups, decodes them to a phase, and locks onto the phase cycle.
- Checks phase sequence, per-phase dwell time and right-of-way safety, and reports 1-cycle error pulses plus sticky error flags.
- Sits beside the controller, in the testbench or as a silicon safety monitor; it never drives lights.

Parameters:
- DWELL_P1, 8, cycles in P1 (M1 G, M2 G, MT R, S R)
- DWELL_P2, 3, cycles in P2 (M1 G, M2 Y, MT R, S R)
- DWELL_P3, 6, cycles in P3 (M1 G, M2 R, MT G, S R)
- DWELL_P4, 3, cycles in P4 (M1 Y, M2 R, MT Y, S R)
- DWELL_P5, 4, cycles in P5 (M1 R, M2 R, MT R, S G)
- DWELL_P6, 3, cycles in P6 (M1 R, M2 R, MT R, S Y)
- DW_W, 4, dwell counter width; every DWELL_Px must be ≤ 2^DW_W-2
- CNT_W, 8, width of cycles_done

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- light_M1  in  3  main road 1 (001 green, 010 yellow, 100 red)
- light_M2  in  3  main road 2
- light_MT  in  3  main-road turn
- light_S  in  3  side road
- clr_err  in  1  clears err_sticky
- phase  out  3  decoded phase 0..5 = P1..P6; 7 = invalid
- phase_valid  out  1  sample matches P1..P6
- locked  out  1  monitor synchronised to the cycle
- err_pattern  out  1  pulse: sample is not a legal phase pattern
- err_conflict  out  1  pulse: conflicting greens present
- err_seq  out  1  pulse: illegal phase transition
- err_dwell  out  1  pulse: dwell too short or overstay
- err_sticky  out  4  {dwell, seq, conflict, pattern}, set-only until clr_err
- cycles_done  out  CNT_W  count of completed P6->P1 wraps while locked; wraps modulo 2^CNT_W

Behaviour:
- Reset (sync, rst=1 at edge) gives: phase=7, phase_valid=0, locked=0, all pulses 0, err_sticky=0, cycles_done=0. Internal state also clears: sample reg=0, previous phase=7, dwell counter=0, overstay flag=0.
- Pipeline: stage 1 registers the four light inputs. Stage 2 registers decode and check results.
- Latency: a light value present in cycle k appears on phase and on the pulses in cycle k+2.
- Decode: each group must be exactly 001, 010 or 100 and the tuple must match one of P1..P6. Otherwise phase=7, phase_valid=0.
- Conflict: asserted when MT is green together with M2 green, or S is green together with any other green. A conflicting sample also asserts err_pattern.
- Invalid sample: err_pattern pulses on every invalid sample. The same cycle also clears locked and the dwell counter and sets previous phase=7.
- Dwell counter: reset to 1 on a phase change. Otherwise it increments while the phase is unchanged and saturates at 2^DW_W-1.
- Lock: unlocked at reset. locked goes to 1 on the first change between two valid phases. Dwell and sequence are not checked on that first change.
- Sequence (while locked): a phase change must be next(prev), with P6->P1 wrapping.
  - Violation: err_seq pulses and the monitor resynchronises to the new phase; locked stays 1.
  - The dwell check of the departing phase is still performed on a violating change.
- Dwell (while locked):
  - Overstay: when the counter equals DWELL_prev and the phase is still unchanged, err_dwell pulses once and the overstay flag is set.
  - Change check: on a phase change with the counter ≠ DWELL_prev, err_dwell pulses, unless the overstay flag was already set.
  - The overstay flag clears on every phase change.
- cycles_done increments on a locked P6->P1 change, including when err_dwell fires in the same cycle.
- Sticky bits: err_sticky bits set on the corresponding pulse. clr_err clears them. If clr_err coincides with a pulse, the pulse wins and the bit is left set.
- Several errors may pulse in the same cycle, for example seq+dwell or pattern+conflict.

Decomposition:
- Shared package traffic_light_pkg contains:
  - light encodings GREEN/YELLOW/RED
  - phase codes P1..P6 and PH_INVALID=7
  - default dwell constants, also used by the controller
  - sticky bit index constants
- One combinational sub-module, traffic_light_phase_decoder:
  - inputs: the four light groups
  - outputs: phase, phase_valid, conflict
  - the monitor instantiates it on the stage-1 registers

Test Plan:
- Nominal controller, 3 full cycles after reset -> locked=1 after the first P1->P2; no error pulses; cycles_done=3; err_sticky=0.
- P3 held 5 cycles instead of 6 -> one err_dwell pulse at the P3->P4 change; err_sticky=4'b1000; sequence continues without err_seq.
- P1 held 10 cycles -> err_dwell pulses once, at the 9th P1 sample; no second pulse at the P1->P2 change.
- Sequence P1 to P3 directly (P2 skipped) -> err_seq pulse; locked stays 1; the next P3->P4 is checked normally.
- Lights M1=G, M2=G, MT=G, S=R for 1 cycle -> err_pattern=1, err_conflict=1, phase=7, locked=0; relock on the next valid change. All-zero lights -> err_pattern only.
- clr_err asserted in the same cycle as an err_seq pulse -> err_sticky[2] stays 1; clr_err alone next cycle -> err_sticky=0. rst mid-P4 -> all outputs at reset values, locked=0.
